// File: rtl/adder.sv
// Registered adder: c <= a + b with one cycle of latency and async active-high reset.
// Define ADDER_SIGNED_EN to treat a and b as two's complement (sign-extended before the add).
module adder #(
  parameter int unsigned WIDTH_IN  = 4,
  parameter int unsigned WIDTH_OUT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH_IN-1:0]  a,
  input  logic [WIDTH_IN-1:0]  b,
  output logic [WIDTH_OUT-1:0] c
);

  // Adder width: wide enough for a carry-out and for the full output width.
  localparam int unsigned EXT_W = (WIDTH_IN + 1 > WIDTH_OUT) ? (WIDTH_IN + 1) : WIDTH_OUT;

  generate
    if (WIDTH_IN < 1 || WIDTH_OUT < 1) begin : g_bad_width
      $fatal(1, "adder: WIDTH_IN and WIDTH_OUT must both be >= 1");
    end
  endgenerate

  logic [EXT_W-1:0] a_ext;
  logic [EXT_W-1:0] b_ext;

`ifdef ADDER_SIGNED_EN
  assign a_ext = EXT_W'($signed(a));
  assign b_ext = EXT_W'($signed(b));
`else
  assign a_ext = EXT_W'(a);
  assign b_ext = EXT_W'(b);
`endif

  // rst_n is asserted high despite its name; reset wins over a coincident clock edge.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      c <= '0;
    end else begin
      c <= WIDTH_OUT'(a_ext + b_ext);
    end
  end

endmodule

// File: tb/tb_adder.sv
// Randomized self-checking bench for adder against an integer-arithmetic reference model.
module tb_adder;

  localparam int unsigned WI = 4;
  localparam int unsigned WO = 8;

  logic          clk;
  logic          rst_n;
  logic [WI-1:0] a;
  logic [WI-1:0] b;
  logic [WO-1:0] c;

  int n_cmp;
  int n_bad;

  adder #(.WIDTH_IN(WI), .WIDTH_OUT(WO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .c    (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: interpret operands as integers, add, reduce modulo 2^WO.
  function automatic logic [WO-1:0] model(input logic [WI-1:0] x, input logic [WI-1:0] y);
    int vx;
    int vy;
    vx = int'(x);
    vy = int'(y);
`ifdef ADDER_SIGNED_EN
    if (vx >= (1 << (WI - 1))) vx = vx - (1 << WI);
    if (vy >= (1 << (WI - 1))) vy = vy - (1 << WI);
`endif
    return WO'(vx + vy);
  endfunction

  task automatic check(input string tag, input logic [WO-1:0] got, input logic [WO-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [WI-1:0] seq_a [4];
  logic [WI-1:0] seq_b [4];
  logic [WO-1:0] seq_e [4];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    seq_a = '{4'd0, 4'd5, 4'd8, 4'd15};
    seq_b = '{4'd0, 4'd9, 4'd8, 4'd1};
`ifdef ADDER_SIGNED_EN
    seq_e = '{8'h00, 8'hFE, 8'hF0, 8'h00};
`else
    seq_e = '{8'd0, 8'd14, 8'd16, 8'd16};
`endif

    // Reset held across clock edges
    rst_n = 1'b1;
    a = 4'h3;
    b = 4'h4;
    #1;
    check("reset_async", c, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold", c, 8'h00);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("reset_release", c, 8'h07);

    // Basic and max operands
    @(negedge clk);
    a = 4'b0001;
    b = 4'b0001;
    @(negedge clk);
    check("basic", c, 8'h02);
    a = 4'hF;
    b = 4'hF;
    @(negedge clk);
`ifdef ADDER_SIGNED_EN
    check("max", c, 8'hFE);
`else
    check("max", c, 8'h1E);
`endif

    // Back-to-back pairs
    for (int i = 0; i < 4; i++) begin
      a = seq_a[i];
      b = seq_b[i];
      @(negedge clk);
      check($sformatf("b2b%0d", i), c, seq_e[i]);
    end

    // Async reset mid-stream
    a = 4'hF;
    b = 4'hF;
    @(negedge clk);
    check("pre_reset", c, model(4'hF, 4'hF));
    #2;
    rst_n = 1'b1;
    #1;
    check("mid_reset", c, 8'h00);
    a = 4'h6;
    b = 4'h7;
    @(posedge clk);
    #1;
    check("reset_wins_edge", c, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("post_reset", c, model(4'h6, 4'h7));

`ifdef ADDER_SIGNED_EN
    a = 4'h7;
    b = 4'h1;
    @(negedge clk);
    check("signed_7p1", c, 8'h08);
`endif

    // Randomized operands, one new pair per cycle
    for (int i = 0; i < 300; i++) begin
      logic [WI-1:0] ra;
      logic [WI-1:0] rb;
      ra = WI'($urandom);
      rb = WI'($urandom);
      a = ra;
      b = rb;
      @(negedge clk);
      check("random", c, model(ra, rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
